// File: rtl/counter_pkg.sv
// Shared constants and arithmetic helpers for the modulo-N up/down counter.
// Both the RTL and the bench's reference checks use these helpers.
package counter_pkg;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  typedef struct packed {
    logic [31:0] count;
    logic        wrap;
  } step_t;

  typedef struct packed {
    logic [31:0] m;
    logic        err;
  } cfg_t;

  // The wrap is always taken through an explicit compare, so M = 2^WIDTH
  // wraps correctly even though the result is later truncated to WIDTH.
  function automatic step_t next_count(input logic [31:0] count,
                                       input logic [31:0] m,
                                       input logic        dir);
    step_t r;
    r.wrap = 1'b0;
    if (dir == DIR_UP) begin
      if (count == m - 32'd1) begin
        r.count = '0;
        r.wrap  = 1'b1;
      end else begin
        r.count = count + 32'd1;
      end
    end else begin
      if (count == '0) begin
        r.count = m - 32'd1;
        r.wrap  = 1'b1;
      end else begin
        r.count = count - 32'd1;
      end
    end
    return r;
  endfunction

  function automatic cfg_t clamp_modulus(input logic [31:0] req,
                                         input logic [31:0] max_m);
    cfg_t r;
    if (req < 32'd2) begin
      r.m   = 32'd2;
      r.err = 1'b1;
    end else if (req > max_m) begin
      r.m   = max_m;
      r.err = 1'b1;
    end else begin
      r.m   = req;
      r.err = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/mod_n_updown_counter_if.sv
// Control/data bundle of the modulo-N counter; the bench drives the master side.
interface mod_n_updown_counter_if #(
   parameter int MAX_MODULUS = 16
);
   localparam int WIDTH = $clog2(MAX_MODULUS);
   localparam int MW    = $clog2(MAX_MODULUS + 1);

   logic             en;
   logic             load_in;
   logic [WIDTH-1:0] data_in;
   logic             up_down;
   logic             cfg_load;
   logic [MW-1:0]    mod_in;
   logic [WIDTH-1:0] data_out;
   logic [MW-1:0]    modulus_out;
   logic             tc_out;
   logic             load_err;
   logic             cfg_err;

   modport master (
      output en, load_in, data_in, up_down, cfg_load, mod_in,
      input  data_out, modulus_out, tc_out, load_err, cfg_err
   );

   modport slave (
      input  en, load_in, data_in, up_down, cfg_load, mod_in,
      output data_out, modulus_out, tc_out, load_err, cfg_err
   );
endinterface

// File: rtl/mod_cfg_reg.sv
// Modulus register: range-clamps mod_in on cfg_load and pulses cfg_err when clamped.
module mod_cfg_reg
   import counter_pkg::*;
#(
   parameter int MAX_MODULUS     = 16,
   parameter int DEFAULT_MODULUS = 12,
   localparam int MW             = $clog2(MAX_MODULUS + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cfg_load,
   input  logic [MW-1:0] mod_in,
   output logic [MW-1:0] m_out,
   output logic          cfg_err
);
   logic [MW-1:0] m_d, m_q;
   logic          cfg_err_d, cfg_err_q;
   cfg_t          cfg;
   logic          unused_cfg_bits;

   assign cfg             = clamp_modulus(32'(mod_in), 32'(MAX_MODULUS));
   assign unused_cfg_bits = ^cfg.m[31:MW];

   // NOTE: every always_comb output gets a default first, so no latch is inferred.
   always_comb begin
      m_d       = m_q;
      cfg_err_d = 1'b0;
      if (cfg_load) begin
         m_d       = cfg.m[MW-1:0];
         cfg_err_d = cfg.err;
      end
   end

   // NOTE: state updates use non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (rst) begin
         m_q       <= MW'(DEFAULT_MODULUS);
         cfg_err_q <= 1'b0;
      end else begin
         m_q       <= m_d;
         cfg_err_q <= cfg_err_d;
      end
   end

   assign m_out   = m_q;
   assign cfg_err = cfg_err_q;
endmodule

// File: rtl/mod_n_updown_counter.sv
// Loadable modulo-N up/down counter with enable, programmable modulus and wrap pulse.
// Priority each edge: rst > cfg_load > load_in > en step > hold.
module mod_n_updown_counter
   import counter_pkg::*;
#(
   parameter int MAX_MODULUS     = 16,
   parameter int DEFAULT_MODULUS = 12
) (
   input  logic                   clk,
   input  logic                   rst,
   mod_n_updown_counter_if.slave  bus
);
   localparam int WIDTH = $clog2(MAX_MODULUS);
   localparam int MW    = $clog2(MAX_MODULUS + 1);

   logic [MW-1:0]    m;
   logic [WIDTH-1:0] count_d, count_q;
   logic             tc_d, tc_q;
   logic             load_err_d, load_err_q;
   step_t            step;
   logic             unused_step_bits;

   mod_cfg_reg #(
      .MAX_MODULUS     (MAX_MODULUS),
      .DEFAULT_MODULUS (DEFAULT_MODULUS)
   ) u_cfg (
      .clk      (clk),
      .rst      (rst),
      .cfg_load (bus.cfg_load),
      .mod_in   (bus.mod_in),
      .m_out    (m),
      .cfg_err  (bus.cfg_err)
   );

   assign step             = next_count(32'(count_q), 32'(m), bus.up_down);
   assign unused_step_bits = ^step.count[31:WIDTH];

   // Loads are checked against the modulus active before this edge.
   always_comb begin
      count_d    = count_q;
      tc_d       = 1'b0;
      load_err_d = 1'b0;
      if (bus.cfg_load) begin
         count_d = '0;
      end else if (bus.load_in) begin
         if (MW'(bus.data_in) < m) begin
            count_d = bus.data_in;
         end else begin
            count_d    = WIDTH'(m - MW'(1));
            load_err_d = 1'b1;
         end
      end else if (bus.en) begin
         count_d = step.count[WIDTH-1:0];
         tc_d    = step.wrap;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q    <= '0;
         tc_q       <= 1'b0;
         load_err_q <= 1'b0;
      end else begin
         count_q    <= count_d;
         tc_q       <= tc_d;
         load_err_q <= load_err_d;
      end
   end

   assign bus.data_out    = count_q;
   assign bus.modulus_out = m;
   assign bus.tc_out      = tc_q;
   assign bus.load_err    = load_err_q;
endmodule

// File: tb/tb_mod_n_updown_counter.sv
// Directed bench for mod_n_updown_counter at MAX_MODULUS=16, DEFAULT_MODULUS=12.
module tb_mod_n_updown_counter;
   import counter_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   tests_run    = 0;
   int   tests_failed = 0;

   mod_n_updown_counter_if #(.MAX_MODULUS(16)) bus ();

   mod_n_updown_counter #(
      .MAX_MODULUS     (16),
      .DEFAULT_MODULUS (12)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string tag, input int data, input int m,
                            input int tc, input int lerr, input int cerr);
      check({tag, ".data"},     int'(bus.data_out),    data);
      check({tag, ".mod"},      int'(bus.modulus_out), m);
      check({tag, ".tc"},       int'(bus.tc_out),      tc);
      check({tag, ".load_err"}, int'(bus.load_err),    lerr);
      check({tag, ".cfg_err"},  int'(bus.cfg_err),     cerr);
   endtask

   task automatic set_inputs(input logic en, input logic ld, input int din,
                             input logic dir, input logic cfg, input int mod);
      bus.en       = en;
      bus.load_in  = ld;
      bus.data_in  = 4'(din);
      bus.up_down  = dir;
      bus.cfg_load = cfg;
      bus.mod_in   = 5'(mod);
   endtask

   int up_exp[14]   = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 0, 1, 2};
   int down_exp[13] = '{11, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 11};
   int m5_exp[6]    = '{1, 2, 3, 4, 0, 1};
   int tog_exp[4]   = '{6, 5, 6, 5};

   initial begin
      step_t s;
      cfg_t  c;

      // Package helpers against hand values
      s = next_count(32'd11, 32'd12, DIR_UP);
      check("fn.up_wrap", int'(s.count) * 2 + int'(s.wrap), 1);
      s = next_count(32'd0, 32'd16, DIR_DOWN);
      check("fn.down_wrap", int'(s.count) * 2 + int'(s.wrap), 31);
      c = clamp_modulus(32'd1, 32'd16);
      check("fn.clamp_low", int'(c.m) * 2 + int'(c.err), 5);

      // Reset
      rst = 1'b1;
      set_inputs(1'b1, 1'b0, 0, DIR_UP, 1'b0, 0);
      tick();
      check_all("reset", 0, 12, 0, 0, 0);

      // Up count through the wrap
      rst = 1'b0;
      for (int i = 0; i < 14; i++) begin
         tick();
         check($sformatf("up%0d.data", i), int'(bus.data_out), up_exp[i]);
         check($sformatf("up%0d.tc", i), int'(bus.tc_out), (up_exp[i] == 0) ? 1 : 0);
      end

      // Reset again, then down count
      rst = 1'b1;
      tick();
      check("rst2.data", int'(bus.data_out), 0);
      rst = 1'b0;
      bus.up_down = DIR_DOWN;
      for (int i = 0; i < 13; i++) begin
         tick();
         check($sformatf("dn%0d.data", i), int'(bus.data_out), down_exp[i]);
         check($sformatf("dn%0d.tc", i), int'(bus.tc_out), (i == 0 || i == 12) ? 1 : 0);
      end

      // Loads: in range, out of range, then the error clears
      set_inputs(1'b0, 1'b1, 7, DIR_UP, 1'b0, 0);
      tick();
      check_all("load7", 7, 12, 0, 0, 0);
      bus.data_in = 4'd13;
      tick();
      check_all("load13", 11, 12, 0, 1, 0);
      bus.load_in = 1'b0;
      tick();
      check_all("hold_after_load", 11, 12, 0, 0, 0);

      // Reprogram to M=5 at count 9, then count up through the new wrap
      set_inputs(1'b0, 1'b1, 9, DIR_UP, 1'b0, 0);
      tick();
      check("load9.data", int'(bus.data_out), 9);
      set_inputs(1'b0, 1'b0, 0, DIR_UP, 1'b1, 5);
      tick();
      check_all("cfg5", 0, 5, 0, 0, 0);
      set_inputs(1'b1, 1'b0, 0, DIR_UP, 1'b0, 0);
      for (int i = 0; i < 6; i++) begin
         tick();
         check($sformatf("m5_%0d.data", i), int'(bus.data_out), m5_exp[i]);
         check($sformatf("m5_%0d.tc", i), int'(bus.tc_out), (m5_exp[i] == 0) ? 1 : 0);
      end

      // Out-of-range moduli clamp and flag
      set_inputs(1'b0, 1'b0, 0, DIR_UP, 1'b1, 1);
      tick();
      check_all("cfg1", 0, 2, 0, 0, 1);
      bus.cfg_load = 1'b0;
      tick();
      check_all("cfg_err_clear", 0, 2, 0, 0, 0);
      set_inputs(1'b0, 1'b0, 0, DIR_UP, 1'b1, 20);
      tick();
      check_all("cfg20", 0, 16, 0, 0, 1);

      // M=16: up-wrap at all-ones, then hold with en=0
      set_inputs(1'b0, 1'b1, 15, DIR_UP, 1'b0, 0);
      tick();
      check_all("load15", 15, 16, 0, 0, 0);
      set_inputs(1'b1, 1'b0, 0, DIR_UP, 1'b0, 0);
      tick();
      check_all("wrap16", 0, 16, 1, 0, 0);
      tick();
      check_all("step16", 1, 16, 0, 0, 0);
      bus.en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_all($sformatf("hold%0d", i), 1, 16, 0, 0, 0);
      end

      // cfg_load wins over a simultaneous load_in
      set_inputs(1'b1, 1'b1, 3, DIR_UP, 1'b1, 16);
      tick();
      check_all("cfg_plus_load", 0, 16, 0, 0, 0);

      // rst wins over a simultaneous load_in and restores the default modulus
      set_inputs(1'b0, 1'b1, 9, DIR_UP, 1'b0, 0);
      tick();
      check("pre_rst.data", int'(bus.data_out), 9);
      rst = 1'b1;
      set_inputs(1'b1, 1'b1, 5, DIR_UP, 1'b1, 7);
      tick();
      check_all("rst_plus_load", 0, 12, 0, 0, 0);
      rst = 1'b0;

      // Direction toggled every cycle from 5
      set_inputs(1'b0, 1'b1, 5, DIR_UP, 1'b0, 0);
      tick();
      check("load5.data", int'(bus.data_out), 5);
      bus.load_in = 1'b0;
      bus.en      = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.up_down = (i % 2 == 0) ? DIR_UP : DIR_DOWN;
         tick();
         check($sformatf("tog%0d.data", i), int'(bus.data_out), tog_exp[i]);
         check($sformatf("tog%0d.tc", i), int'(bus.tc_out), 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
